// File: rtl/spi_rx_fifo_pkg.sv
// Shared definitions for the SPI slave receive path: link mode constants,
// default word width and receive FSM state encodings.
package spi_rx_fifo_pkg;

  localparam int SPI_MODE   = 0;
  localparam bit MSB_FIRST  = 1'b1;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/spi_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push while full is accepted only
// when a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  // When full and popping, wr_ptr == rd_ptr: the slot being overwritten is the
  // head that leaves this cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == DEPTH_C);
    end
  end

endmodule

// File: rtl/spi_rx_fifo.sv
// SPI mode-0 slave receiver: synchronizes sck/mosi/ss into clk, deserializes
// MSB-first words into a FIFO and raises spi_block when the FIFO is nearly full.
//
// state    | meaning
// ST_IDLE  | waiting for a synchronized ss falling edge; sck ignored
// ST_SHIFT | frame active; shifting mosi on each sck rise, pushing every DATA_W bits
module spi_rx_fifo
  import spi_rx_fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = 4,
  parameter int BLOCK_TH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              mosi,
  input  logic              ss,
  input  logic              rd_en,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              spi_block,
  output logic              ovf,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0]  TH_C     = (ADDR_W+1)'(BLOCK_TH);

  logic [2:0]        sck_sync, ss_sync;
  logic [1:0]        mosi_sync;
  logic              sck_rise, ss_fall, ss_rise, mosi_s;
  rx_state_e         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              push_r, drop, part_err;

  // ss flops reset low so a master already holding ss low at release shows no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck};
      ss_sync   <= {ss_sync[1:0], ss};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign ss_fall  = ~ss_sync[1] & ss_sync[2];
  assign ss_rise  = ss_sync[1] & ~ss_sync[2];
  assign mosi_s   = mosi_sync[1];
  assign part_err = (state == ST_SHIFT) & ss_rise & (bit_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      push_r  <= 1'b0;
    end else begin
      push_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ss_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else if (sck_rise) begin
            shreg <= {shreg[DATA_W-2:0], mosi_s};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              push_r  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // shreg holds the completed word for the push cycle; sck is far slower than clk.
  sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_r),
    .pop     (rd_en),
    .wr_data (shreg),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign drop = push_r & full & ~rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_block <= 1'b0;
      ovf       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      spi_block <= (DEPTH_C - count) < TH_C;
      ovf       <= drop | (ovf & ~clr_flags);
      frame_err <= part_err | (frame_err & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Scenario bench for spi_rx_fifo: drives SPI frames at sck = clk/8 and checks
// received words against a scoreboard queue plus status flags and latency.
module tb_spi_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n, sck, mosi, ss, rd_en, clr_flags;
  logic [31:0] rd_data;
  logic        empty, full, spi_block, ovf, frame_err;
  logic [4:0]  count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_w;

  spi_rx_fifo #(.DATA_W(32), .ADDR_W(4), .BLOCK_TH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (sck),
    .mosi      (mosi),
    .ss        (ss),
    .rd_en     (rd_en),
    .clr_flags (clr_flags),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .spi_block (spi_block),
    .ovf       (ovf),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  // Each bit: 4 clk low (mosi set on entry), 4 clk high; returns with sck low.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); mosi = w[31-i];
      repeat (3) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  // Final bit rise only; the caller holds sck high for 4 negedges then drops it.
  task automatic last_rise(input logic b);
    @(negedge clk); mosi = b;
    repeat (3) @(negedge clk);
    sck = 1'b1;
  endtask

  task automatic frame_begin();
    @(negedge clk); ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk); ss = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0)      begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (count !== 5'd0)     begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (rd_data !== 32'h0)  begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_cmp++; if (spi_block !== 1'b0) begin n_err++; $display("FAIL reset_block: got %b want 0", spi_block); end
    n_cmp++; if (ovf !== 1'b0)       begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] w;
    w = 32'hDEADBEEF;
    frame_begin();
    send_bits(w, 31);
    last_rise(w[0]);
    sb.push_back(w);
    repeat (3) @(negedge clk);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_early: empty got %b want 1 at 3 clk", empty); end
    @(negedge clk);
    sck = 1'b0;
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_latency: empty got %b want 0 at 4 clk", empty); end
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
    exp_w = sb.pop_front();
    n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL single_data: got %h want %h", rd_data, exp_w); end
    frame_end();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL single_pop_empty: got %b want 1", empty); end
    n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL single_pop_data: got %h want 0", rd_data); end
  endtask

  task automatic test_fill();
    frame_begin();
    for (int i = 0; i < 16; i++) begin
      send_bits(32'(i), 32);
      sb.push_back(32'(i));
      @(negedge clk);
      n_cmp++; if (count !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
      n_cmp++; if (spi_block !== (i + 1 >= 13)) begin n_err++; $display("FAIL fill_block[%0d]: got %b want %b", i, spi_block, (i + 1 >= 13)); end
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", full); end
    send_bits(32'h0000_0099, 32);
    @(negedge clk);
    n_cmp++; if (ovf !== 1'b1)    begin n_err++; $display("FAIL fill_ovf: got %b want 1", ovf); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_ovf_count: got %0d want 16", count); end
    frame_end();
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL fill_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] w;
    w = 32'h1234_5678;
    pulse_clr();
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fpp_clr_ovf: got %b want 0", ovf); end
    frame_begin();
    send_bits(w, 31);
    last_rise(w[0]);
    repeat (3) @(negedge clk);
    exp_w = sb.pop_front();
    n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL fpp_old_head: got %h want %h", rd_data, exp_w); end
    rd_en = 1'b1;
    sb.push_back(w);
    @(negedge clk);
    rd_en = 1'b0;
    sck = 1'b0;
    @(negedge clk);
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fpp_count: got %0d want 16", count); end
    n_cmp++; if (ovf !== 1'b0)    begin n_err++; $display("FAIL fpp_ovf: got %b want 0", ovf); end
    n_cmp++; if (full !== 1'b1)   begin n_err++; $display("FAIL fpp_full: got %b want 1", full); end
    frame_end();
    for (int i = 0; i < 16; i++) begin
      exp_w = sb.pop_front();
      n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, exp_w); end
      n_cmp++; if (count !== 5'(16 - i)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 16 - i); end
      rd_en = 1'b1;
      @(negedge clk);
    end
    rd_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_cmp++; if (spi_block !== 1'b0) begin n_err++; $display("FAIL drain_block: got %b want 0", spi_block); end
  endtask

  task automatic test_frame_err();
    frame_begin();
    send_bits(32'hFFFF_FFFF, 20);
    frame_end();
    n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    n_cmp++; if (count !== 5'd0)     begin n_err++; $display("FAIL ferr_count: got %0d want 0", count); end
    frame_begin();
    send_bits(32'h0000_0001, 32);
    sb.push_back(32'h0000_0001);
    frame_end();
    n_cmp++; if (count !== 5'd1)     begin n_err++; $display("FAIL ferr_next_count: got %0d want 1", count); end
    n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
    exp_w = sb.pop_front();
    n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL ferr_next_data: got %h want %h", rd_data, exp_w); end
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    pulse_clr();
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_clr: got %b want 0", frame_err); end
  endtask

  task automatic test_reset_mid();
    frame_begin();
    for (int i = 0; i < 3; i++) send_bits(32'hC0DE_0000 + 32'(i), 32);
    @(negedge clk);
    n_cmp++; if (count !== 5'd3) begin n_err++; $display("FAIL rmid_pre_count: got %0d want 3", count); end
    send_bits(32'hFFFF_FFFF, 10);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (count !== 5'd0)     begin n_err++; $display("FAIL rmid_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1)     begin n_err++; $display("FAIL rmid_empty: got %b want 1", empty); end
    n_cmp++; if (rd_data !== 32'h0)  begin n_err++; $display("FAIL rmid_rd_data: got %h want 0", rd_data); end
    n_cmp++; if (spi_block !== 1'b0) begin n_err++; $display("FAIL rmid_block: got %b want 0", spi_block); end
    n_cmp++; if (ovf !== 1'b0 || frame_err !== 1'b0) begin n_err++; $display("FAIL rmid_flags: got ovf=%b ferr=%b want 0/0", ovf, frame_err); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_bits(32'hFFFF_FFFF, 32);
    @(negedge clk);
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL rmid_ss_low_idle: got count %0d want 0", count); end
    frame_end();
    frame_begin();
    send_bits(32'hA5A5_A5A5, 32);
    sb.push_back(32'hA5A5_A5A5);
    frame_end();
    n_cmp++; if (count !== 5'd1)     begin n_err++; $display("FAIL rmid_after_count: got %0d want 1", count); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rmid_after_ferr: got %b want 0", frame_err); end
    exp_w = sb.pop_front();
    n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL rmid_after_data: got %h want %h", rd_data, exp_w); end
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rmid_final_empty: got %b want 1", empty); end
  endtask

  initial begin
    rst_n = 1'b0; sck = 1'b0; mosi = 1'b0; ss = 1'b1; rd_en = 1'b0; clr_flags = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full_push_pop();
    test_frame_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_rx_fifo.md
# spi_rx_fifo

SPI slave receiver with an internal word FIFO: the receiving end of the fifo_spi transmitter link. It samples the master's sck/mosi/ss in the 50 MHz system clock domain, deserializes 32-bit words, and buffers them for a local consumer. It drives spi_block back to the master so the master stops starting new words before the FIFO can overflow.

## Interface
- DATA_W, 32, word width in bits; also the number of sck edges per word
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W = 16 words
- BLOCK_TH, 4, spi_block asserts when free entries < BLOCK_TH
- clk  in  1  system clock (50 MHz); all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sck  in  1  SPI clock from master, asynchronous to clk
- mosi  in  1  SPI serial data from master, asynchronous to clk
- ss  in  1  SPI slave select, active-low, asynchronous to clk
- rd_en  in  1  pop head word; ignored when empty
- clr_flags  in  1  clears ovf and frame_err
- rd_data  out  DATA_W  FIFO head word (first-word fall-through); 0 when empty
- empty  out  1  FIFO holds no words
- full  out  1  FIFO holds 2**ADDR_W words
- count  out  ADDR_W+1  words stored
- spi_block  out  1  back-pressure to master
- ovf  out  1  sticky: a completed word was dropped because the FIFO was full
- frame_err  out  1  sticky: ss deasserted mid-word

## Operation
- SPI mode 0 (CPOL=0, CPHA=0), MSB first; mosi sampled on sck rising edge.
- sck, mosi, ss each pass through a 2-flop synchronizer. A third flop on sck and on ss provides edge detection. mosi is sampled in the same cycle the synchronized sck rise is detected.
- Receive FSM with two states:
  - IDLE: on synchronized ss falling edge -> SHIFT, bit_cnt=0.
  - SHIFT: on each sck rise, shreg={shreg[DATA_W-2:0],mosi_s} and bit_cnt++.
  - On the DATA_W-th rise, the assembled word is pushed and bit_cnt returns to 0. The FSM stays in SHIFT, so multiple words per ss frame are allowed.
  - On ss rising edge: if bit_cnt!=0, the partial word is discarded and frame_err is set. Either way the FSM goes to IDLE.
  - sck edges in IDLE are ignored.
- Push when full: the word is dropped and ovf is set. Exception: if rd_en is asserted in the same cycle as a push while full, the push is accepted and count is unchanged.
- Simultaneous push and pop when not full or empty: both take effect and count is unchanged. A pop when empty is ignored.
- Pointers wrap modulo 2**ADDR_W.
- spi_block = (2**ADDR_W - count) < BLOCK_TH, registered from the updated count.
- clr_flags clears both sticky flags. A set event in the same cycle as clr_flags wins.
- Reset values: FSM=IDLE, bit_cnt=0, shreg=0, pointers=0, count=0, empty=1, full=0, rd_data=0, spi_block=0, ovf=0, frame_err=0.
- rst_n assertion mid-word discards the partial word and all FIFO contents.
- After reset release, the FSM waits for a fresh ss falling edge. If ss is already low at release, no edge is seen and the FSM stays IDLE until ss has toggled.

## Timing
- sck frequency must be <= clk/8; high and low phases each >= 4 clk.
- ss setup to the first sck rise must be >= 4 clk.
- Latency from the physical sck rise of the last bit to the word visible (empty=0, rd_data valid): 4 clk. That is 2 sync + 1 edge detect + 1 push.
- Pop: rd_en at cycle N; the next head word is on rd_data and count is decremented at N+1.
- spi_block updates 1 clk after the count change.
- The master must sample spi_block before starting each word. BLOCK_TH >= 1 guarantees room for the in-flight word.

## Structure
- The shared include file holds: the SPI mode constant, MSB-first flag, DATA_W default, and the FSM state encodings (ST_IDLE=1'b0, ST_SHIFT=1'b1).
- Sub-module sync_fifo (parameters DATA_W, ADDR_W) contains: the memory, pointers, count, full/empty, FWFT read and the simultaneous push/pop rule. It is reused elsewhere for CDC-free buffering.
- The top level contains: synchronizers, edge detect, FSM, shift register, sticky flags and spi_block.

## Test plan
- One frame of 0xDEADBEEF at sck=clk/8 -> count=1, rd_data=0xDEADBEEF 4 clk after the last rise; rd_en -> empty=1, rd_data=0.
- 16 words 0..15 in one ss frame with no reads -> full=1, count=16, spi_block=1 from count 13 onward. A 17th word -> dropped, ovf=1, and the FIFO contents are unchanged.
- ss raised after 20 bits -> frame_err=1, count unchanged. The next frame with 0x00000001 -> received correctly. clr_flags -> frame_err=0.
- FIFO full and rd_en in the same cycle as a word push -> count stays 16, ovf stays 0, and the pop returns the old head.
- rst_n pulsed at bit 10 of a word, with 3 words buffered -> all outputs return to reset values. A following full frame with 0xA5A5A5A5 is received alone.
